// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the 5-stage MIPS core with hold, bubble
// insertion, in-place operand refresh while held and a saturating stall counter.
module pipe_stage_reg #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int TNEW_W      = 2,
  parameter int NUM_OPS     = 2,
  parameter int TNEW_DEC    = 1,
  parameter int STALL_CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        valid_in,
  input  logic [DATA_W-1:0]           instr_in,
  input  logic [DATA_W-1:0]           pc_in,
  input  logic [NUM_OPS*DATA_W-1:0]   ops_in,
  input  logic [DATA_W-1:0]           imm_in,
  input  logic [ADDR_W-1:0]           waddr_in,
  input  logic                        regwrite_in,
  input  logic [TNEW_W-1:0]           tnew_in,
  input  logic [NUM_OPS-1:0]          refresh_en,
  input  logic [NUM_OPS*DATA_W-1:0]   refresh_data,
  output logic                        valid_out,
  output logic [DATA_W-1:0]           instr_out,
  output logic [DATA_W-1:0]           pc_out,
  output logic [NUM_OPS*DATA_W-1:0]   ops_out,
  output logic [DATA_W-1:0]           imm_out,
  output logic [ADDR_W-1:0]           waddr_out,
  output logic                        regwrite_out,
  output logic [TNEW_W-1:0]           tnew_out,
  output logic [STALL_CNT_W-1:0]      stall_cnt
);

  logic                      valid_q,    valid_d;
  logic [DATA_W-1:0]         instr_q,    instr_d;
  logic [DATA_W-1:0]         pc_q,       pc_d;
  logic [NUM_OPS*DATA_W-1:0] ops_q,      ops_d;
  logic [DATA_W-1:0]         imm_q,      imm_d;
  logic [ADDR_W-1:0]         waddr_q,    waddr_d;
  logic                      regwrite_q, regwrite_d;
  logic [TNEW_W-1:0]         tnew_q,     tnew_d;
  logic [STALL_CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  always_comb begin
    valid_d     = valid_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    ops_d       = ops_q;
    imm_d       = imm_q;
    waddr_d     = waddr_q;
    regwrite_d  = regwrite_q;
    tnew_d      = tnew_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      // A bubble still carries its PC for EPC / delay-slot bookkeeping.
      valid_d    = 1'b0;
      instr_d    = '0;
      pc_d       = pc_in;
      ops_d      = '0;
      imm_d      = '0;
      waddr_d    = '0;
      regwrite_d = 1'b0;
      tnew_d     = '0;
    end else if (stall) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if (refresh_en[i]) begin
          ops_d[i*DATA_W +: DATA_W] = refresh_data[i*DATA_W +: DATA_W];
        end
      end
      if (valid_q && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
    end else begin
      valid_d    = valid_in;
      instr_d    = instr_in;
      pc_d       = pc_in;
      ops_d      = ops_in;
      imm_d      = imm_in;
      waddr_d    = waddr_in;
      regwrite_d = regwrite_in && (waddr_in != '0);
      if (TNEW_DEC != 0) begin
        tnew_d = (tnew_in != '0) ? (tnew_in - TNEW_W'(1)) : '0;
      end else begin
        tnew_d = tnew_in;
      end
      if (valid_in) begin
        stall_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      instr_q     <= '0;
      pc_q        <= '0;
      ops_q       <= '0;
      imm_q       <= '0;
      waddr_q     <= '0;
      regwrite_q  <= 1'b0;
      tnew_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      ops_q       <= ops_d;
      imm_q       <= imm_d;
      waddr_q     <= waddr_d;
      regwrite_q  <= regwrite_d;
      tnew_q      <= tnew_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign valid_out    = valid_q;
  assign instr_out    = instr_q;
  assign pc_out       = pc_q;
  assign ops_out      = ops_q;
  assign imm_out      = imm_q;
  assign waddr_out    = waddr_q;
  assign regwrite_out = regwrite_q;
  assign tnew_out     = tnew_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the 5-stage MIPS core; one instance serves any boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries instruction, PC, NUM_OPS operand channels, immediate, destination address, write-enable and Tnew.
- Adds hold (stall), flush (bubble insert), valid tracking, in-place operand refresh while held, $0 write suppression and a saturating stall-cycle counter.

Parameters:
- DATA_W, 32, width of instr, pc, imm and each operand channel
- ADDR_W, 5, destination register address width
- TNEW_W, 2, Tnew field width
- NUM_OPS, 2, number of operand channels (1..4)
- TNEW_DEC, 1, 1 = saturating decrement of Tnew on load; 0 = pass through unchanged
- STALL_CNT_W, 8, stall counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold current contents
- flush  in  1  replace contents with a bubble
- valid_in  in  1  upstream slot holds a real instruction
- instr_in  in  DATA_W  instruction word
- pc_in  in  DATA_W  instruction PC
- ops_in  in  NUM_OPS*DATA_W  operand channels; channel i at bits [i*DATA_W +: DATA_W]
- imm_in  in  DATA_W  extended immediate
- waddr_in  in  ADDR_W  destination register
- regwrite_in  in  1  register write enable
- tnew_in  in  TNEW_W  cycles until the result is available
- refresh_en  in  NUM_OPS  per-channel forward capture while held
- refresh_data  in  NUM_OPS*DATA_W  forwarded values, same packing as ops_in
- valid_out  out  1  registered valid
- instr_out  out  DATA_W  registered instruction
- pc_out  out  DATA_W  registered PC
- ops_out  out  NUM_OPS*DATA_W  registered operands
- imm_out  out  DATA_W  registered immediate
- waddr_out  out  ADDR_W  registered destination
- regwrite_out  out  1  registered write enable
- tnew_out  out  TNEW_W  registered Tnew
- stall_cnt  out  STALL_CNT_W  count of cycles held with valid_out=1

Behaviour:
- Reset asserted (reset=0), asynchronously: every output and internal register goes to 0; this takes priority over all other inputs.
- All outputs are driven directly by registers; there is no combinational path from any input to any output.
- Latency is 1 cycle on load.
- Priority on each rising edge with reset=1: flush > stall > load.
- Flush:
  - instr, ops, imm, waddr, regwrite, tnew and valid are loaded with 0.
  - pc is loaded from pc_in, so a bubble keeps a PC for EPC/delay-slot use.
  - Flush overrides stall in the same cycle.
  - stall_cnt is not changed.
- Stall, without flush:
  - All fields hold their values.
  - For each channel i, if refresh_en[i]=1, ops channel i loads refresh_data channel i; otherwise it holds.
  - tnew holds; it is not decremented while held.
  - If valid_out=1, stall_cnt increments by 1 and saturates at all-ones (no wrap). If valid_out=0, stall_cnt holds.
- Load (neither flush nor stall):
  - All fields are captured from their inputs; refresh_en is ignored.
  - regwrite is loaded as regwrite_in AND (waddr_in != 0), so a write to $0 is never asserted.
  - valid is loaded from valid_in.
  - tnew is loaded as tnew_in-1 when TNEW_DEC=1 and tnew_in>0; it is loaded as 0 when tnew_in=0; it is loaded as tnew_in when TNEW_DEC=0.
  - stall_cnt is cleared to 0 when a new valid instruction is loaded (valid_in=1). It holds when valid_in=0.
- When valid_in=0 on load, the other fields are still captured as presented; downstream logic qualifies them with valid_out.
- Reset deasserting mid-stall: the first rising edge after release applies the normal priority rules to the zeroed contents.
- The NUM_OPS=1 configuration must elaborate with no unused-slice warnings.

Test Plan:
- Reset release, then load instr=0x012A4020, pc=0x3000, ops={0x5,0x7}, waddr=8, regwrite=1, tnew=2 -> the next cycle shows all fields captured, tnew_out=1, valid_out=1.
- Load tnew_in=0; then load tnew_in=3 with TNEW_DEC=0 -> tnew_out=0, then tnew_out=3.
- Load waddr_in=0 with regwrite_in=1 -> regwrite_out=0 and waddr_out=0.
- Stall 3 cycles with valid_out=1 and refresh_en=2'b10, refresh_data ch1=0xDEAD in cycle 2:
  - ch0 holds 0x5; ch1=0xDEAD from cycle 3.
  - stall_cnt reads 1, 2, 3.
  - A following valid load clears stall_cnt to 0.
- Assert stall and flush together with pc_in=0x3008 -> instr_out=0, valid_out=0, regwrite_out=0, tnew_out=0, pc_out=0x3008, stall_cnt unchanged.
- Pull reset low between clock edges during a stall -> all outputs read 0 immediately, before the next edge. With STALL_CNT_W=2, hold 5 cycles -> stall_cnt reads 1, 2, 3, 3, 3.
